// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle sequencer for datapath_core. Steps FETCH -> EXEC (-> MEM for
//   loads) per instruction and produces the full datapath control word each
//   cycle from the state, the fetched instruction and the ALU status flags.
//   An undefined opcode either parks the sequencer in HALT until reset
//   (HALT_ON_UNDEF=1) or is skipped as a NOP (HALT_ON_UNDEF=0).
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   IR      in   [31:0] instruction register contents
//   SF      in   [3:0]  ALU status {V,C,N,Z}
//   AS      out  RAM address select (1 = PC, 0 = ALU result)
//   DS      out  [1:0] data select (00 ALU, 01 store path, 11 RAM data)
//   PS      out  [1:0] PC op (00 hold, 01 PC+4, 10 PC+(K<<2))
//   PC_Sel  out  PC-relative source select
//   K_Sel   out  ALU B operand select (1 = K)
//   IL      out  instruction register load
//   SL      out  status register load
//   FS      out  [4:0] ALU function
//   C0      out  ALU carry-in
//   MW      out  memory write enable
//   RW      out  register file write enable
//   DA/SA/SB out [4:0] destination / A / B register addresses
//   K       out  [DATA_W-1:0] extended immediate
//   halted  out  high while in HALT
module control_unit #(
  parameter int DATA_W        = 64,
  parameter bit HALT_ON_UNDEF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IR,
  input  logic [3:0]        SF,
  output logic              AS,
  output logic [1:0]        DS,
  output logic [1:0]        PS,
  output logic              PC_Sel,
  output logic              K_Sel,
  output logic              IL,
  output logic              SL,
  output logic [4:0]        FS,
  output logic              C0,
  output logic              MW,
  output logic              RW,
  output logic [4:0]        DA,
  output logic [4:0]        SA,
  output logic [4:0]        SB,
  output logic [DATA_W-1:0] K,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  state_t state, state_next;

  // Instruction fields
  logic [4:0] rd, rn, rm;
  assign rd = IR[4:0];
  assign rn = IR[9:5];
  assign rm = IR[20:16];

  // Immediates: arithmetic (zero-ext), data transfer, branch, compare-branch
  logic [DATA_W-1:0] k_ari, k_dt, k_br, k_cb;
  assign k_ari = {{(DATA_W-12){1'b0}}, IR[21:10]};
  assign k_dt  = {{(DATA_W-9){IR[20]}}, IR[20:12]};
  assign k_br  = {{(DATA_W-26){IR[25]}}, IR[25:0]};
  assign k_cb  = {{(DATA_W-19){IR[23]}}, IR[23:5]};

  // Opcode decode
  logic is_addi, is_subi, is_add, is_sub, is_and, is_orr;
  logic is_stur, is_ldur, is_b, is_cbz, is_cbnz;
  assign is_addi = (IR[31:22] == 10'b1001000100);
  assign is_subi = (IR[31:22] == 10'b1101000100);
  assign is_add  = (IR[31:21] == 11'b10001011000);
  assign is_sub  = (IR[31:21] == 11'b11001011000);
  assign is_and  = (IR[31:21] == 11'b10001010000);
  assign is_orr  = (IR[31:21] == 11'b10101010000);
  assign is_stur = (IR[31:21] == 11'b11111000000);
  assign is_ldur = (IR[31:21] == 11'b11111000010);
  assign is_b    = (IR[31:26] == 6'b000101);
  assign is_cbz  = (IR[31:24] == 8'b10110100);
  assign is_cbnz = (IR[31:24] == 8'b10110101);

  // Only the zero flag steers the sequencer; V, C and N are ignored here.
  logic unused_flags;
  assign unused_flags = ^SF[3:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    AS = 1'b0; DS = 2'b00; PS = 2'b00; PC_Sel = 1'b0; K_Sel = 1'b0;
    IL = 1'b0; SL = 1'b0;  FS = FS_AND; C0 = 1'b0;    MW = 1'b0;
    RW = 1'b0; DA = 5'd0;  SA = 5'd0;  SB = 5'd0;     K = '0;
    halted = 1'b0;
    state_next = state;
    // Outputs are gated with rst so that no enable can fire while reset
    // is held, even though the control word is combinational.
    if (rst) begin
      case (state)
        FETCH: begin
          AS = 1'b1; DS = 2'b11; IL = 1'b1; PS = 2'b01;
          state_next = EXEC;
        end
        EXEC: begin
          state_next = FETCH;
          if (is_addi || is_subi) begin
            SA = rn; DA = rd; K = k_ari; K_Sel = 1'b1; RW = 1'b1;
            FS = is_subi ? FS_SUB : FS_ADD;
            C0 = is_subi;
            SL = is_subi;
          end else if (is_add || is_sub || is_and || is_orr) begin
            SA = rn; SB = rm; DA = rd; RW = 1'b1;
            if (is_add)      FS = FS_ADD;
            else if (is_sub) FS = FS_SUB;
            else if (is_orr) FS = FS_ORR;
            else             FS = FS_AND;
            C0 = is_sub;
            SL = is_sub;
          end else if (is_stur) begin
            SA = rn; SB = rd; K = k_dt; K_Sel = 1'b1; FS = FS_ADD;
            DS = 2'b01; MW = 1'b1;
          end else if (is_ldur) begin
            SA = rn; K = k_dt; K_Sel = 1'b1; FS = FS_ADD;
            state_next = MEM;
          end else if (is_b) begin
            K = k_br; PS = 2'b10;
          end else if (is_cbz || is_cbnz) begin
            SA = 5'd31; SB = rd; FS = FS_ADD; K = k_cb;
            // CBZ branches on Z set, CBNZ on Z clear.
            if (SF[0] == is_cbz) PS = 2'b10;
          end else begin
            state_next = HALT_ON_UNDEF ? HALT : FETCH;
          end
        end
        MEM: begin
          // Address operands held from the LDUR EXEC cycle.
          SA = rn; K = k_dt; K_Sel = 1'b1; FS = FS_ADD;
          DS = 2'b11; DA = rd; RW = 1'b1;
          state_next = FETCH;
        end
        HALT: begin
          halted = 1'b1;
          state_next = HALT;
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic [3:0]  SF;
  logic        AS, PC_Sel, K_Sel, IL, SL, C0, MW, RW, halted;
  logic [1:0]  DS, PS;
  logic [4:0]  FS, DA, SA, SB;
  logic [63:0] K;

  control_unit #(.DATA_W(64), .HALT_ON_UNDEF(1'b1)) dut (
    .clk(clk), .rst(rst), .IR(IR), .SF(SF),
    .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel), .K_Sel(K_Sel),
    .IL(IL), .SL(SL), .FS(FS), .C0(C0), .MW(MW), .RW(RW),
    .DA(DA), .SA(SA), .SB(SB), .K(K), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       as;
    logic [1:0] ds;
    logic [1:0] ps;
    logic       pc_sel;
    logic       k_sel;
    logic       il;
    logic       sl;
    logic [4:0] fs;
    logic       c0;
    logic       mw;
    logic       rw;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [63:0] k;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  sf;
    ctl_t        exp;
    string       name;
  } vec_t;

  typedef enum int {I_ADDI, I_SUBI, I_ADD, I_SUB, I_AND, I_ORR, I_STUR,
                    I_LDUR, I_B, I_CBZ, I_CBNZ, I_UNDEF} ikind_t;
  typedef enum int {PH_FETCH, PH_EXEC, PH_MEM, PH_HALT} phase_t;

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];

  function automatic ctl_t ctl(input logic as_, input logic [1:0] ds_,
      input logic [1:0] ps_, input logic pcs_, input logic ks_, input logic il_,
      input logic sl_, input logic [4:0] fs_, input logic c0_, input logic mw_,
      input logic rw_, input logic [4:0] da_, input logic [4:0] sa_,
      input logic [4:0] sb_, input logic [63:0] k_, input logic h_);
    ctl_t c;
    c.as = as_; c.ds = ds_; c.ps = ps_; c.pc_sel = pcs_; c.k_sel = ks_;
    c.il = il_; c.sl = sl_; c.fs = fs_; c.c0 = c0_; c.mw = mw_; c.rw = rw_;
    c.da = da_; c.sa = sa_; c.sb = sb_; c.k = k_; c.halted = h_;
    return c;
  endfunction

  function automatic ctl_t actual();
    ctl_t c;
    c.as = AS; c.ds = DS; c.ps = PS; c.pc_sel = PC_Sel; c.k_sel = K_Sel;
    c.il = IL; c.sl = SL; c.fs = FS; c.c0 = C0; c.mw = MW; c.rw = RW;
    c.da = DA; c.sa = SA; c.sb = SB; c.k = K; c.halted = halted;
    return c;
  endfunction

  task automatic check(input string name, input ctl_t exp);
    ctl_t act;
    act = actual();
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (IR=%h SF=%b)", name, act, exp, IR, SF);
  endtask

  task automatic add(input logic [31:0] ir, input logic [3:0] sf,
                     input ctl_t exp, input string name);
    vec_t v;
    v.ir = ir; v.sf = sf; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  function automatic ikind_t classify(input logic [31:0] ir);
    int op11;
    op11 = int'(ir[31:21]);
    if (ir[31:22] == 10'h244) return I_ADDI;       // 1001000100
    if (ir[31:22] == 10'h344) return I_SUBI;       // 1101000100
    if (op11 == 11'h458) return I_ADD;
    if (op11 == 11'h658) return I_SUB;
    if (op11 == 11'h450) return I_AND;
    if (op11 == 11'h550) return I_ORR;
    if (op11 == 11'h7C0) return I_STUR;
    if (op11 == 11'h7C2) return I_LDUR;
    if (ir[31:26] == 6'h05) return I_B;
    if (ir[31:24] == 8'hB4) return I_CBZ;
    if (ir[31:24] == 8'hB5) return I_CBNZ;
    return I_UNDEF;
  endfunction

  function automatic ctl_t model(input phase_t ph, input logic [31:0] ir,
                                 input logic [3:0] sf);
    ctl_t c;
    ikind_t kd;
    longint dt_off, br_off, cb_off;
    c = '0;
    kd = classify(ir);
    dt_off = longint'($signed(ir[20:12]));
    br_off = longint'($signed(ir[25:0]));
    cb_off = longint'($signed(ir[23:5]));
    case (ph)
      PH_FETCH: begin c.as = 1; c.ds = 3; c.il = 1; c.ps = 1; end
      PH_HALT:  c.halted = 1;
      PH_MEM: begin
        c.sa = ir[9:5]; c.k = dt_off; c.k_sel = 1; c.fs = 8;
        c.ds = 3; c.da = ir[4:0]; c.rw = 1;
      end
      PH_EXEC: begin
        case (kd)
          I_ADDI, I_SUBI: begin
            c.sa = ir[9:5]; c.da = ir[4:0]; c.k = 64'(ir[21:10]); c.k_sel = 1;
            c.rw = 1; c.fs = (kd == I_SUBI) ? 9 : 8;
            c.c0 = (kd == I_SUBI); c.sl = (kd == I_SUBI);
          end
          I_ADD, I_SUB, I_AND, I_ORR: begin
            c.sa = ir[9:5]; c.sb = ir[20:16]; c.da = ir[4:0]; c.rw = 1;
            c.fs = (kd == I_ADD) ? 8 : (kd == I_SUB) ? 9 : (kd == I_ORR) ? 4 : 0;
            c.c0 = (kd == I_SUB); c.sl = (kd == I_SUB);
          end
          I_STUR: begin
            c.sa = ir[9:5]; c.sb = ir[4:0]; c.k = dt_off; c.k_sel = 1;
            c.fs = 8; c.ds = 1; c.mw = 1;
          end
          I_LDUR: begin
            c.sa = ir[9:5]; c.k = dt_off; c.k_sel = 1; c.fs = 8;
          end
          I_B: begin c.k = br_off; c.ps = 2; end
          I_CBZ, I_CBNZ: begin
            c.sa = 31; c.sb = ir[4:0]; c.fs = 8; c.k = cb_off;
            if ((kd == I_CBZ && sf[0]) || (kd == I_CBNZ && !sf[0])) c.ps = 2;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic phase_t next_phase(input phase_t ph, input logic [31:0] ir);
    case (ph)
      PH_FETCH: return PH_EXEC;
      PH_EXEC: begin
        if (classify(ir) == I_LDUR)  return PH_MEM;
        if (classify(ir) == I_UNDEF) return PH_HALT;
        return PH_FETCH;
      end
      PH_MEM:  return PH_FETCH;
      default: return PH_HALT;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, d;
    int sel;
    a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
    sel = $urandom_range(0, 11);
    case (sel)
      0:  return {10'b1001000100, 12'($urandom), a, d};
      1:  return {10'b1101000100, 12'($urandom), a, d};
      2:  return {11'b10001011000, b, 6'($urandom), a, d};
      3:  return {11'b11001011000, b, 6'($urandom), a, d};
      4:  return {11'b10001010000, b, 6'($urandom), a, d};
      5:  return {11'b10101010000, b, 6'($urandom), a, d};
      6:  return {11'b11111000000, 9'($urandom), 2'b00, a, d};
      7:  return {11'b11111000010, 9'($urandom), 2'b00, a, d};
      8:  return {6'b000101, 26'($urandom)};
      9:  return {8'b10110100, 19'($urandom), d};
      10: return {8'b10110101, 19'($urandom), d};
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ctl_t fw, zero, hw;
    phase_t ph;
    int halt_cnt;
    logic [31:0] cur_ir;

    fw   = ctl(1, 2'b11, 2'b01, 0, 0, 1, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 0);
    zero = '0;
    hw   = ctl(0, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 1);

    add(32'h91001FE2, 4'b0000, fw, "fetch_addi");
    add(32'h91001FE2, 4'b0000,
        ctl(0, 0, 0, 0, 1, 0, 0, 5'b01000, 0, 0, 1, 5'd2, 5'd31, 5'd0, 64'd7, 0), "exec_addi");
    add(32'hF800E043, 4'b0000, fw, "fetch_stur");
    add(32'hF800E043, 4'b0000,
        ctl(0, 2'b01, 0, 0, 1, 0, 0, 5'b01000, 0, 1, 0, 5'd0, 5'd2, 5'd3, 64'd14, 0), "exec_stur");
    add(32'hF8400061, 4'b0000, fw, "fetch_ldur");
    add(32'hF8400061, 4'b0000,
        ctl(0, 0, 0, 0, 1, 0, 0, 5'b01000, 0, 0, 0, 5'd0, 5'd3, 5'd0, 64'd0, 0), "exec_ldur");
    add(32'hF8400061, 4'b0000,
        ctl(0, 2'b11, 0, 0, 1, 0, 0, 5'b01000, 0, 0, 1, 5'd1, 5'd3, 5'd0, 64'd0, 0), "mem_ldur");
    add(32'hB4FFFFC5, 4'b0001, fw, "fetch_cbz_t");
    add(32'hB4FFFFC5, 4'b0001,
        ctl(0, 0, 2'b10, 0, 0, 0, 0, 5'b01000, 0, 0, 0, 5'd0, 5'd31, 5'd5,
            64'hFFFF_FFFF_FFFF_FFFE, 0), "exec_cbz_taken");
    add(32'hB4FFFFC5, 4'b0000, fw, "fetch_cbz_nt");
    add(32'hB4FFFFC5, 4'b0000,
        ctl(0, 0, 2'b00, 0, 0, 0, 0, 5'b01000, 0, 0, 0, 5'd0, 5'd31, 5'd5,
            64'hFFFF_FFFF_FFFF_FFFE, 0), "exec_cbz_not_taken");
    add(32'hCB020024, 4'b0000, fw, "fetch_sub");
    add(32'hCB020024, 4'b0000,
        ctl(0, 0, 0, 0, 0, 0, 1, 5'b01001, 1, 0, 1, 5'd4, 5'd1, 5'd2, 64'd0, 0), "exec_sub");
    add(32'h00000000, 4'b0000, fw, "fetch_undef");
    add(32'h00000000, 4'b0000, zero, "exec_undef");
    for (int i = 0; i < 5; i++) add(32'h00000000, 4'b1111, hw, "halt_hold");

    rst = 1'b0; IR = '0; SF = '0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", zero);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      IR = vecs[i].ir; SF = vecs[i].sf;
      #1 check(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Leave HALT through reset
    rst = 1'b0;
    #1 check("halt_reset", zero);
    @(negedge clk);
    rst = 1'b1;
    #1 check("after_halt_fetch", fw);

    // Reset asserted in the middle of a load
    IR = 32'hF8400061;
    @(negedge clk);
    #1 check("mid_ldur_exec", model(PH_EXEC, IR, SF));
    rst = 1'b0;
    #1 check("mid_ldur_reset", zero);
    @(negedge clk);
    #1 check("mid_ldur_reset_hold", zero);
    rst = 1'b1;
    #1 check("mid_ldur_restart", fw);
    @(negedge clk);

    // Randomized instruction stream against the reference model
    ph = PH_EXEC;  // the restart FETCH above was consumed at the last edge
    cur_ir = IR;
    halt_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (ph == PH_FETCH) cur_ir = rand_instr();
      IR = cur_ir;
      SF = 4'($urandom);
      if ((ph == PH_HALT && halt_cnt >= 3) || $urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #1 check("rand_reset", zero);
        ph = PH_FETCH;
        halt_cnt = 0;
      end else begin
        rst = 1'b1;
        #1 check("rand_cycle", model(ph, cur_ir, SF));
        halt_cnt = (ph == PH_HALT) ? halt_cnt + 1 : 0;
        ph = next_phase(ph, cur_ir);
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer that drives every control input of datapath_core.
- Each cycle it issues the control word that a bench would otherwise drive by hand, from the fetched instruction (IR_Out) and the ALU status (SF).
- Runs FETCH -> EXEC (-> MEM for loads) per instruction.
- Decodes a LEGv8 subset; an unknown opcode halts the sequencer until reset.

Parameters:
- DATA_W, 64, width of the K immediate output.
- HALT_ON_UNDEF, 1, 1 = enter HALT on an undefined opcode; 0 = treat it as a NOP and go to FETCH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- IR  input  32  instruction register contents (datapath IR_Out).
- SF  input  4  ALU status {V,C,N,Z}; combinational from the current ALU result.
- AS  output  1  RAM address select: 1 = PC, 0 = ALU result.
- DS  output  2  data select: 00 = ALU, 01 = store path, 11 = RAM read data.
- PS  output  2  PC op: 00 hold, 01 PC+4, 10 PC+(K<<2).
- PC_Sel  output  1  PC-relative source select; 0 whenever PS = 10.
- K_Sel  output  1  ALU B operand: 1 = K, 0 = register SB.
- IL  output  1  instruction register load.
- SL  output  1  status register load.
- FS  output  5  ALU function: AND 00000, ORR 00100, ADD 01000, SUB 01001.
- C0  output  1  ALU carry-in; 1 for SUB/SUBI, else 0.
- MW  output  1  memory write enable.
- RW  output  1  register file write enable.
- DA, SA, SB  output  5 each  destination / A / B register addresses.
- K  output  DATA_W  extended immediate.
- halted  output  1  high while in HALT.

Behaviour:
- State register: FETCH, EXEC, MEM, HALT.
  - rst low asynchronously forces state FETCH.
  - While rst is low: IL, RW, MW, SL, PS, halted and K are 0; all other outputs are 0.
- FETCH:
  - Outputs: AS=1, DS=11, IL=1, PS=01, RW=0, MW=0. Next state EXEC.
- EXEC: decode IR[31:21]. Field mapping: Rd/Rt = IR[4:0], Rn = IR[9:5], Rm = IR[20:16].
  - ADDI (IR[31:22]=1001000100):
    - SA=Rn, DA=Rd, K=zero-ext IR[21:10], K_Sel=1, FS=ADD, DS=00, RW=1.
  - SUBI (IR[31:22]=1101000100):
    - As ADDI, with FS=SUB, C0=1.
  - ADD / SUB / AND / ORR (IR[31:21] = 10001011000 / 11001011000 / 10001010000 / 10101010000):
    - SA=Rn, SB=Rm, DA=Rd, K_Sel=0, DS=00, RW=1, matching FS and C0.
  - STUR (11111000000):
    - SA=Rn, SB=Rt, K=sign-ext IR[20:12], K_Sel=1, FS=ADD, AS=0, DS=01, MW=1, RW=0.
  - LDUR (11111000010):
    - SA=Rn, K=sign-ext IR[20:12], K_Sel=1, FS=ADD, AS=0, RW=0. Next state MEM.
  - B (IR[31:26]=000101):
    - K=sign-ext IR[25:0], PS=10, PC_Sel=0.
  - CBZ / CBNZ (IR[31:24] = 10110100 / 10110101):
    - SA=31, SB=Rt, K_Sel=0, FS=ADD, K=sign-ext IR[23:5].
    - PS=10 if Z==1 (CBZ) or Z==0 (CBNZ); otherwise PS=00.
  - All non-LDUR instructions go to FETCH next. Unused selects are 0 in every state.
  - Undefined opcode:
    - HALT_ON_UNDEF=1: all enables 0, next state HALT.
    - HALT_ON_UNDEF=0: all enables 0, next state FETCH.
- MEM:
  - Same SA, K, K_Sel, FS, AS=0 as the LDUR EXEC cycle, so the address is held.
  - DS=11, DA=Rt, RW=1. Next state FETCH.
  - Load latency: 3 cycles from FETCH.
- HALT:
  - All enables 0, PS=00, halted=1. Left only by rst.
- SL=1 only for SUBI and SUB.
- Outputs are combinational from state, IR and SF. IR is stable in EXEC and MEM because IL=0 there.
- Reset asserted mid-instruction: no further RW/MW pulses; fetch restarts at FETCH when rst is released.

Test Plan:
- rst=0 for 2 cycles, then 1 -> first cycle: FETCH word (AS=1, IL=1, PS=01, RW=0, MW=0); halted=0.
- IR=32'h91001FE2 (ADDI X2,X31,7) in EXEC -> SA=31, DA=2, K=7, K_Sel=1, FS=01000, RW=1, PS=00; next cycle is FETCH.
- IR=32'hF800E043 (STUR X3,[X2,#14]) -> SA=2, SB=3, K=14, AS=0, MW=1, RW=0.
- IR=32'hF8400061 (LDUR X1,[X3,#0]) -> EXEC: RW=0, AS=0. MEM: DS=11, DA=1, RW=1. Then FETCH.
- IR=32'hB4FFFFC5 (CBZ X5,-2) -> K=64'hFFFF_FFFF_FFFF_FFFE, SB=5. SF=4'b0001 gives PS=10; SF=4'b0000 gives PS=00.
- IR=32'h00000000 -> HALT, halted=1, all enables 0 for 5 cycles. Asserting rst returns to FETCH.
